// File: rtl/qsys_timer_pkg.sv
// Shared definitions for the multi-channel interval timer: register
// offsets, bit positions inside STATUS/CONTROL, per-channel state types
// and helpers that format the state into 32-bit read words.
package qsys_timer_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam int STATUS_TO_BIT  = 0;
  localparam int STATUS_RUN_BIT = 1;

  localparam int CTRL_IE_BIT    = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  // Single-bit state of one channel; the counters live beside it because
  // their width is a parameter of the channel.
  typedef struct packed {
    logic run;
    logic to;
    logic cont;
    logic ie;
  } chan_state_t;

  // One write strobe per register of a channel.
  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
  } chan_wr_t;

  function automatic logic [31:0] status_word(input chan_state_t s);
    logic [31:0] w;
    w = '0;
    w[STATUS_TO_BIT]  = s.to;
    w[STATUS_RUN_BIT] = s.run;
    return w;
  endfunction

  function automatic logic [31:0] control_word(input chan_state_t s);
    logic [31:0] w;
    w = '0;
    w[CTRL_IE_BIT]   = s.ie;
    w[CTRL_CONT_BIT] = s.cont;
    return w;
  endfunction

endpackage

// File: rtl/qsys_timer_channel.sv
// One down-counting timer channel. It counts on the shared prescaler tick
// while RUN is set, reloads from PERIOD after reaching zero and latches a
// timeout flag that, together with IE, forms the channel interrupt.
module qsys_timer_channel
  import qsys_timer_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  chan_wr_t         wr,
  input  logic [CNT_W-1:0] wr_value,
  output chan_state_t      state,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             irq
);

  localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);

  logic timeout;
  logic start;
  logic stop;

  assign timeout = state.run && tick && (count == '0);
  assign start   = wr.control && wr_value[CTRL_START_BIT];
  assign stop    = wr.control && wr_value[CTRL_STOP_BIT];
  assign irq     = state.to && state.ie;

  // Counter, run flag, flags and capture registers; a PERIOD write
  // overrides counting and run control, while timeout still sets TO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= RESET_PERIOD;
      period <= RESET_PERIOD;
      snap   <= '0;
      state  <= '0;
    end else begin
      if (wr.period) begin
        period    <= wr_value;
        count     <= wr_value;
        state.run <= 1'b0;
      end else begin
        if (state.run && tick) begin
          count <= timeout ? period : count - CNT_W'(1);
        end
        if (start) begin
          state.run <= 1'b1;
        end else if (stop || (timeout && !state.cont)) begin
          state.run <= 1'b0;
        end
      end

      if (wr.control) begin
        state.ie   <= wr_value[CTRL_IE_BIT];
        state.cont <= wr_value[CTRL_CONT_BIT];
      end

      if (timeout) begin
        state.to <= 1'b1;
      end else if (wr.status) begin
        state.to <= 1'b0;
      end

      if (wr.snap) begin
        snap <= count;
      end
    end
  end

endmodule

// File: rtl/qsys_multi_timer.sv
// Multi-channel interval timer slave. Holds the shared prescaler, the
// register decode and the registered read mux; each channel is a
// qsys_timer_channel instance selected by the upper address bits.
module qsys_multi_timer
  import qsys_timer_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 32,
  parameter int PRESCALE       = 1,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(N_CH)+1:0]   address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [N_CH-1:0]           irq,
  output logic                      irq_any
);

  localparam int ADDR_W = $clog2(N_CH) + 2;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic [CH_W-1:0]  ch_sel;
  logic [1:0]       reg_sel;
  logic             wr_en;
  logic [31:0]      rd_next;

  chan_state_t      state_a  [N_CH];
  logic [CNT_W-1:0] count_a  [N_CH];
  logic [CNT_W-1:0] period_a [N_CH];
  logic [CNT_W-1:0] snap_a   [N_CH];

  generate
    if (N_CH > 1) begin : g_multi
      assign ch_sel = address[ADDR_W-1:2];
    end else begin : g_single
      assign ch_sel = '0;
    end
  endgenerate

  assign reg_sel = address[1:0];
  assign wr_en   = chipselect && !write_n;
  assign tick    = (ps_cnt == '0);
  assign irq_any = |irq;

  // Shared prescaler: counts down and reloads, giving one tick per PRESCALE clocks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ps_cnt <= PS_RELOAD;
    end else if (tick) begin
      ps_cnt <= PS_RELOAD;
    end else begin
      ps_cnt <= ps_cnt - PS_W'(1);
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      chan_wr_t wr;
      logic     hit;

      assign hit        = wr_en && (ch_sel == CH_W'(i));
      assign wr.status  = hit && (reg_sel == REG_STATUS);
      assign wr.control = hit && (reg_sel == REG_CONTROL);
      assign wr.period  = hit && (reg_sel == REG_PERIOD);
      assign wr.snap    = hit && (reg_sel == REG_SNAP);

      qsys_timer_channel #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_channel (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .wr       (wr),
        .wr_value (writedata[CNT_W-1:0]),
        .state    (state_a[i]),
        .count    (count_a[i]),
        .period   (period_a[i]),
        .snap     (snap_a[i]),
        .irq      (irq[i])
      );
    end
  endgenerate

  // Read mux: selects the addressed channel's register; unmapped channels read 0.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        case (reg_sel)
          REG_STATUS:  rd_next = status_word(state_a[i]);
          REG_CONTROL: rd_next = control_word(state_a[i]);
          REG_PERIOD:  rd_next = 32'(period_a[i]);
          default:     rd_next = 32'(snap_a[i]);
        endcase
      end
    end
  end

  // Registered read data, refreshed every cycle from the mux.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_qsys_multi_timer.sv
// Directed bench for qsys_multi_timer. Two instances share clock and reset:
// "a" runs with PRESCALE=1 and "b" with PRESCALE=4. Register reads push the
// expected word to a scoreboard queue and pop it when readdata is valid.
module tb_qsys_multi_timer;

  logic        clk;
  logic        reset_n;

  logic [2:0]  a_address;
  logic        a_chipselect;
  logic        a_write_n;
  logic [31:0] a_writedata;
  logic [31:0] a_readdata;
  logic [1:0]  a_irq;
  logic        a_irq_any;

  logic [2:0]  b_address;
  logic        b_chipselect;
  logic        b_write_n;
  logic [31:0] b_writedata;
  logic [31:0] b_readdata;
  logic [1:0]  b_irq;
  logic        b_irq_any;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_compared;
  int n_mismatched;

  // Addresses: {channel, register}
  localparam logic [2:0] C0_STATUS  = 3'd0;
  localparam logic [2:0] C0_CONTROL = 3'd1;
  localparam logic [2:0] C0_PERIOD  = 3'd2;
  localparam logic [2:0] C0_SNAP    = 3'd3;
  localparam logic [2:0] C1_STATUS  = 3'd4;
  localparam logic [2:0] C1_CONTROL = 3'd5;
  localparam logic [2:0] C1_PERIOD  = 3'd6;
  localparam logic [2:0] C1_SNAP    = 3'd7;

  qsys_multi_timer #(
    .N_CH(2), .CNT_W(32), .PRESCALE(1), .DEFAULT_PERIOD(49999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (a_address),
    .chipselect (a_chipselect),
    .write_n    (a_write_n),
    .writedata  (a_writedata),
    .readdata   (a_readdata),
    .irq        (a_irq),
    .irq_any    (a_irq_any)
  );

  qsys_multi_timer #(
    .N_CH(2), .CNT_W(32), .PRESCALE(4), .DEFAULT_PERIOD(49999)
  ) dut_ps4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (b_address),
    .chipselect (b_chipselect),
    .write_n    (b_write_n),
    .writedata  (b_writedata),
    .readdata   (b_readdata),
    .irq        (b_irq),
    .irq_any    (b_irq_any)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One bus write, occupying exactly one rising edge.
  task automatic applyStimulus(input bit use_b, input logic [2:0] addr,
                               input logic [31:0] data);
    @(negedge clk);
    if (use_b) begin
      b_address = addr; b_writedata = data; b_chipselect = 1'b1; b_write_n = 1'b0;
    end else begin
      a_address = addr; a_writedata = data; a_chipselect = 1'b1; a_write_n = 1'b0;
    end
    @(posedge clk);
    #1;
    a_chipselect = 1'b0; a_write_n = 1'b1;
    b_chipselect = 1'b0; b_write_n = 1'b1;
  endtask

  // One bus read; the expectation rides the scoreboard until readdata is valid.
  task automatic readReg(input bit use_b, input logic [2:0] addr,
                         input logic [31:0] expected, input string tag);
    sb_item_t item;
    @(negedge clk);
    if (use_b) begin
      b_address = addr; b_chipselect = 1'b1; b_write_n = 1'b1;
    end else begin
      a_address = addr; a_chipselect = 1'b1; a_write_n = 1'b1;
    end
    sb.push_back('{tag: tag, exp: expected});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      item = sb.pop_front();
      checkOutput(item.tag, use_b ? b_readdata : a_readdata, item.exp);
    end
    a_chipselect = 1'b0;
    b_chipselect = 1'b0;
  endtask

  // Hold reset low for one rising edge and check the reset-visible outputs.
  task automatic resetPulse(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_a_readdata"}, a_readdata, 32'd0);
    checkOutput({tag, "_a_irq"}, 32'(a_irq), 32'd0);
    checkOutput({tag, "_a_irq_any"}, 32'(a_irq_any), 32'd0);
    checkOutput({tag, "_b_readdata"}, b_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit found;
    int lat;

    n_compared   = 0;
    n_mismatched = 0;
    reset_n      = 1'b0;
    a_address = '0; a_chipselect = 1'b0; a_write_n = 1'b1; a_writedata = '0;
    b_address = '0; b_chipselect = 1'b0; b_write_n = 1'b1; b_writedata = '0;

    // Reset values of both channels
    resetPulse("rst0");
    readReg(0, C0_STATUS,  32'd0,     "rst_c0_status");
    readReg(0, C0_CONTROL, 32'd0,     "rst_c0_control");
    readReg(0, C0_PERIOD,  32'd49999, "rst_c0_period");
    readReg(0, C0_SNAP,    32'd0,     "rst_c0_snap");
    readReg(0, C1_PERIOD,  32'd49999, "rst_c1_period");

    // Continuous mode, PERIOD=4: irq every 5 cycles
    applyStimulus(0, C0_PERIOD, 32'd4);
    applyStimulus(0, C0_CONTROL, 32'h7);
    repeat (4) @(posedge clk);
    #1 checkOutput("cont_irq_before", 32'(a_irq[0]), 32'd0);
    @(posedge clk);
    #1 checkOutput("cont_irq_first", 32'(a_irq[0]), 32'd1);
    checkOutput("cont_irq_any", 32'(a_irq_any), 32'd1);
    applyStimulus(0, C0_STATUS, 32'd0);
    repeat (3) @(posedge clk);
    #1 checkOutput("cont_irq_cleared", 32'(a_irq[0]), 32'd0);
    @(posedge clk);
    #1 checkOutput("cont_irq_second", 32'(a_irq[0]), 32'd1);

    // STATUS clear in the same cycle as a timeout leaves TO set
    applyStimulus(0, C0_STATUS, 32'd0);
    #1 checkOutput("clr_irq_low", 32'(a_irq[0]), 32'd0);
    repeat (3) @(posedge clk);
    applyStimulus(0, C0_STATUS, 32'd0);
    readReg(0, C0_STATUS, 32'h3, "clr_race_status");

    // STOP, then START+STOP together
    applyStimulus(0, C0_CONTROL, 32'h8);
    readReg(0, C0_STATUS,  32'h1, "stop_status");
    readReg(0, C0_CONTROL, 32'h0, "stop_control");
    checkOutput("stop_irq_masked", 32'(a_irq[0]), 32'd0);
    applyStimulus(0, C0_CONTROL, 32'hC);
    readReg(0, C0_STATUS, 32'h3, "startstop_status");

    // Channel isolation and snapshot stability
    resetPulse("rst1");
    applyStimulus(0, C0_PERIOD, 32'd100);
    applyStimulus(0, C0_CONTROL, 32'h6);
    applyStimulus(0, C1_PERIOD, 32'd7);
    applyStimulus(0, C0_SNAP, 32'd0);
    readReg(0, C0_SNAP, 32'd99, "snap_read1");
    repeat (2) @(posedge clk);
    readReg(0, C0_SNAP, 32'd99, "snap_read2");
    applyStimulus(0, C1_SNAP, 32'd0);
    readReg(0, C1_SNAP,   32'd7,   "iso_c1_count");
    readReg(0, C1_STATUS, 32'd0,   "iso_c1_status");
    readReg(0, C1_PERIOD, 32'd7,   "iso_c1_period");
    readReg(0, C0_PERIOD, 32'd100, "iso_c0_period");
    readReg(0, C0_STATUS, 32'h2,   "iso_c0_status");

    // PERIOD write coinciding with a timeout
    applyStimulus(0, C0_PERIOD, 32'd2);
    applyStimulus(0, C0_CONTROL, 32'h6);
    repeat (2) @(posedge clk);
    applyStimulus(0, C0_PERIOD, 32'd5);
    readReg(0, C0_STATUS, 32'h1, "pw_race_status");
    applyStimulus(0, C0_SNAP, 32'd0);
    readReg(0, C0_SNAP, 32'd5, "pw_race_count");

    // PERIOD=0 continuous: timeout on every tick
    applyStimulus(0, C1_PERIOD, 32'd0);
    applyStimulus(0, C1_CONTROL, 32'h7);
    @(posedge clk);
    #1 checkOutput("p0_irq_first", 32'(a_irq[1]), 32'd1);
    applyStimulus(0, C1_STATUS, 32'd0);
    checkOutput("p0_irq_after_clr", 32'(a_irq[1]), 32'd1);
    readReg(0, C1_STATUS, 32'h3, "p0_status");

    // Reset mid-count aborts everything
    applyStimulus(0, C0_PERIOD, 32'd10);
    applyStimulus(0, C0_CONTROL, 32'h7);
    repeat (3) @(posedge clk);
    resetPulse("rst2");
    readReg(0, C0_STATUS,  32'd0,     "mid_c0_status");
    readReg(0, C0_CONTROL, 32'd0,     "mid_c0_control");
    readReg(0, C0_PERIOD,  32'd49999, "mid_c0_period");
    readReg(0, C0_SNAP,    32'd0,     "mid_c0_snap");
    readReg(0, C1_STATUS,  32'd0,     "mid_c1_status");
    applyStimulus(0, C0_SNAP, 32'd0);
    readReg(0, C0_SNAP, 32'd49999, "mid_c0_count");
    repeat (20) @(posedge clk);
    #1 checkOutput("mid_no_irq", 32'(a_irq_any), 32'd0);

    // PRESCALE=4, one-shot PERIOD=2: three ticks to timeout
    applyStimulus(1, C1_PERIOD, 32'd2);
    applyStimulus(1, C1_CONTROL, 32'h5);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(posedge clk);
      #1;
      if (b_irq[1] === 1'b1) begin
        found = 1'b1;
        lat   = i;
      end
    end
    checkOutput("ps4_timeout_seen", 32'(found), 32'd1);
    checkOutput("ps4_latency_in_window", 32'((lat >= 9) && (lat <= 12)), 32'd1);
    checkOutput("ps4_irq_any", 32'(b_irq_any), 32'd1);
    readReg(1, C1_STATUS,  32'h1, "ps4_status");
    readReg(1, C1_CONTROL, 32'h1, "ps4_control");
    applyStimulus(1, C1_SNAP, 32'd0);
    readReg(1, C1_SNAP, 32'd2, "ps4_count");
    readReg(1, C0_STATUS, 32'd0, "ps4_c0_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/qsys_multi_timer.md
QSYS_MULTI_TIMER -- requirements
Module: qsys_multi_timer

Interface
REQ-001 Parameter N_CH, default 2: number of independent timer channels, legal range 1..8.
REQ-002 Parameter CNT_W, default 32: counter, period and snapshot width, legal range 8..32.
REQ-003 Parameter PRESCALE, default 1: clk cycles per counter tick, shared by all channels, legal range 1..65536.
REQ-004 Parameter DEFAULT_PERIOD, default 49999: reset value of every channel's PERIOD register.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 address  input  $clog2(N_CH)+2  upper bits select the channel, low 2 bits select the register.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  N_CH  per-channel interrupt, level, equal to TO AND IE.
REQ-013 irq_any  output  1  OR of irq.

Function
REQ-014 Register map per channel: offset 0 STATUS, offset 1 CONTROL, offset 2 PERIOD, offset 3 SNAP.
REQ-015 STATUS reads {RUN[1], TO[0]}; unused bits read 0; any write clears TO.
REQ-016 CONTROL holds bits IE[0] and CONT[1], which are stored and read back; write bits START[2] and STOP[3] are strobes and read 0.
REQ-017 PERIOD is CNT_W bits, read/write, zero-extended on read; a write also forces COUNT to the new value and clears RUN on the same edge.
REQ-018 Any write to SNAP captures COUNT into SNAP; a read of SNAP returns the captured value.
REQ-019 readdata updates every cycle from the address mux; read latency is 1 cycle; reads have no side effects.
REQ-020 The shared prescaler asserts tick when its down-counter reaches 0, then reloads PRESCALE-1; with PRESCALE=1, tick=1 every cycle.
REQ-021 When RUN=1 and tick=1 and COUNT>0: COUNT decrements by 1.
REQ-022 When RUN=1 and tick=1 and COUNT=0: COUNT reloads PERIOD and TO sets to 1; RUN clears if CONT=0. One period therefore spans PERIOD+1 ticks.
REQ-023 A START strobe sets RUN without altering COUNT; if START and STOP are written together, START wins.
REQ-024 A STOP strobe clears RUN; COUNT holds its value.
REQ-025 If a STATUS-write clear and a timeout event fall in the same cycle, TO ends at 1.
REQ-026 If a PERIOD write and a timeout event fall in the same cycle, the PERIOD write wins: COUNT takes the written value, RUN=0, and TO still sets.
REQ-027 PERIOD=0 in continuous mode: TO sets on every tick.
REQ-028 Channels share nothing except the prescaler and the bus; a write affects only the addressed channel.

Reset
REQ-029 While reset_n=0 at a clk edge, every channel takes: COUNT=DEFAULT_PERIOD, PERIOD=DEFAULT_PERIOD, SNAP=0, CONTROL=0, RUN=0, TO=0.
REQ-030 While reset_n=0 at a clk edge: prescaler=PRESCALE-1, readdata=0, irq=0, irq_any=0.
REQ-031 Reset asserted mid-count aborts the count with no timeout event; reset is sampled only on clk edges.

Structure
REQ-032 Package qsys_timer_pkg shall hold: register offsets, STATUS/CONTROL bit positions, and the channel state struct.
REQ-033 One sub-module, qsys_timer_channel, shall implement one channel and be instantiated N_CH times; the top level holds the prescaler, address decode and read mux.

Verification
REQ-034 PRESCALE=1, ch0 PERIOD=4, CONTROL=0x7 (IE|CONT|START) -> irq[0] rises 5 cycles after START takes effect; after a STATUS clear it recurs every 5 cycles.
REQ-035 PRESCALE=4, ch1 PERIOD=2, one-shot START -> TO set 12 cycles later (±prescaler phase), RUN=0, COUNT=2.
REQ-036 Ch0 running, ch1 idle; write ch1 PERIOD=7 -> ch0 count unaffected; ch1 COUNT=7, RUN=0.
REQ-037 Timeout event coincident with STATUS write -> TO=1; CONTROL write 0xC -> RUN=1.
REQ-038 Ch0 counting, SNAP write, then read SNAP twice 3 cycles apart -> both reads return the same captured COUNT.
REQ-039 reset_n low for 1 cycle mid-count with PERIOD=10 -> all registers at REQ-029/REQ-030 values, irq=0, COUNT=49999.
